// File: rtl/ex_flush_ctrl.sv
// ============================================================================
// Module   : ex_flush_ctrl
// Brief    : Exception/ERTN flush sequencer with held redirect PC and
//            in-flight instruction-fetch response discard tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_flush_ctrl #(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_ex,
   input  logic             ertn_flush,
   input  logic [31:0]      csr_eentry,
   input  logic [31:0]      csr_era,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   input  logic             inst_req_fire,
   input  logic             inst_data_ok,
   output logic             inst_data_drop,
   output logic [CNT_W-1:0] outstanding,
   output logic             ifetch_stall
);

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_REDIRECT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_max_outst = CNT_W'(MAX_OUTST);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_redirect_pc;
   logic [31:0]      w_pc_nxt;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] w_out_nxt;
   logic [CNT_W-1:0] r_discard_cnt;
   logic             w_event;
   logic [31:0]      w_target;
   logic             w_inc;
   logic             w_dec;

   assign w_event  = wb_ex | ertn_flush;
   assign w_target = wb_ex ? csr_eentry : csr_era;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_redirect_pc;
      case (r_state)
         S_IDLE: begin
            if (w_event) begin
               w_state_nxt = S_REDIRECT;
               w_pc_nxt    = w_target;
            end
         end
         S_REDIRECT: begin
            // A new event while a redirect is pending replaces the target.
            if (w_event) begin
               w_pc_nxt = w_target;
            end else if (redirect_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_redirect_pc <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_redirect_pc <= w_pc_nxt;
      end
   end

   // Spurious data_ok at zero and fire at full are both absorbed (no wrap).
   assign w_dec = inst_data_ok & (r_outstanding != '0);
   assign w_inc = inst_req_fire & ((r_outstanding != c_max_outst) | w_dec);

   always_comb begin
      w_out_nxt = r_outstanding;
      case ({w_inc, w_dec})
         2'b10:   w_out_nxt = r_outstanding + CNT_W'(1);
         2'b01:   w_out_nxt = r_outstanding - CNT_W'(1);
         default: w_out_nxt = r_outstanding;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_outstanding <= '0;
         r_discard_cnt <= '0;
      end else begin
         r_outstanding <= w_out_nxt;
         // Every request still in flight after the flush edge carries a stale PC.
         if (w_event) begin
            r_discard_cnt <= w_out_nxt;
         end else if (inst_data_ok && (r_discard_cnt != '0)) begin
            r_discard_cnt <= r_discard_cnt - CNT_W'(1);
         end
      end
   end

   assign flush          = w_event;
   assign redirect_valid = (r_state == S_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign inst_data_drop = inst_data_ok & ((r_discard_cnt != '0) | w_event);
   assign outstanding    = r_outstanding;
   assign ifetch_stall   = (r_outstanding == c_max_outst);

endmodule

`default_nettype wire

// File: tb/tb_ex_flush_ctrl.sv
// ============================================================================
// Module   : tb_ex_flush_ctrl
// Brief    : Vector table, directed corner sequences and random stimulus
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_flush_ctrl;

   localparam int MAXO = 2;
   localparam logic [31:0] EENTRY = 32'h1c008000;
   localparam logic [31:0] ERA    = 32'h1c000100;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_ex, ertn_flush, redirect_ready, inst_req_fire, inst_data_ok;
   logic [31:0] csr_eentry, csr_era;
   logic        flush, redirect_valid, inst_data_drop, ifetch_stall;
   logic [31:0] redirect_pc;
   logic [1:0]  outstanding;

   int n_cmp = 0;
   int n_err = 0;

   ex_flush_ctrl #(.MAX_OUTST(MAXO), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
      .csr_eentry(csr_eentry), .csr_era(csr_era), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .inst_req_fire(inst_req_fire),
      .inst_data_ok(inst_data_ok), .inst_data_drop(inst_data_drop),
      .outstanding(outstanding), .ifetch_stall(ifetch_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic wb, er, rdy, fire, dok;
      logic e_flush, e_drop, e_rv;
      logic [31:0] e_pc;
      logic [1:0] e_out;
      logic e_stall;
   } vec_t;

   vec_t tbl[29];

   // Reference model: one queue entry per in-flight request, 1 = stale.
   bit          m_q[$];
   logic        m_pend;
   logic [31:0] m_pc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = 32'h0;
   endtask

   task automatic drive(input logic wb, er, rdy, fire, dok);
      wb_ex = wb; ertn_flush = er; redirect_ready = rdy;
      inst_req_fire = fire; inst_data_ok = dok;
   endtask

   // Checks at negedge (inputs already settled), then advances the model over the posedge.
   task automatic cyc(input bit use_tbl, input vec_t v);
      logic ev, e_drop;
      bit   popped;
      @(negedge clk);
      ev     = wb_ex | ertn_flush;
      e_drop = inst_data_ok & (ev | (m_q.size() > 0 && m_q[0]));
      if (use_tbl) begin
         chk("tbl_flush", {31'b0, flush}, {31'b0, v.e_flush});
         chk("tbl_drop", {31'b0, inst_data_drop}, {31'b0, v.e_drop});
         chk("tbl_rvalid", {31'b0, redirect_valid}, {31'b0, v.e_rv});
         chk("tbl_rpc", redirect_pc, v.e_pc);
         chk("tbl_outst", {30'b0, outstanding}, {30'b0, v.e_out});
         chk("tbl_stall", {31'b0, ifetch_stall}, {31'b0, v.e_stall});
      end else begin
         chk("mdl_flush", {31'b0, flush}, {31'b0, ev});
         chk("mdl_drop", {31'b0, inst_data_drop}, {31'b0, e_drop});
         chk("mdl_rvalid", {31'b0, redirect_valid}, {31'b0, m_pend});
         chk("mdl_rpc", redirect_pc, m_pc);
         chk("mdl_outst", {30'b0, outstanding}, 32'(m_q.size()));
         chk("mdl_stall", {31'b0, ifetch_stall}, {31'b0, m_q.size() == MAXO});
      end
      if (ev) begin
         foreach (m_q[i]) m_q[i] = 1'b1;
         m_pend = 1'b1;
         m_pc   = wb_ex ? csr_eentry : csr_era;
      end else if (m_pend && redirect_ready) begin
         m_pend = 1'b0;
      end
      popped = 1'b0;
      if (inst_data_ok && m_q.size() > 0) begin
         void'(m_q.pop_front());
         popped = 1'b1;
      end
      if (inst_req_fire && (m_q.size() < MAXO)) m_q.push_back(ev);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t dummy;
      dummy = '{default: '0};
      //            wb er rdy fi dok  fl dr rv  pc      out st
      tbl[0]  = '{1, 0, 0, 0, 0,  1, 0, 0, 32'h0,  2'd0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0,  0, 0, 1, EENTRY, 2'd0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0,  0, 0, 1, EENTRY, 2'd0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0,  0, 0, 1, EENTRY, 2'd0, 0};
      tbl[4]  = '{0, 0, 1, 0, 0,  0, 0, 1, EENTRY, 2'd0, 0};
      tbl[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, EENTRY, 2'd0, 0};
      tbl[6]  = '{1, 1, 0, 0, 0,  1, 0, 0, EENTRY, 2'd0, 0};
      tbl[7]  = '{0, 0, 1, 0, 0,  0, 0, 1, EENTRY, 2'd0, 0};
      tbl[8]  = '{0, 0, 0, 1, 0,  0, 0, 0, EENTRY, 2'd0, 0};
      tbl[9]  = '{0, 0, 0, 1, 0,  0, 0, 0, EENTRY, 2'd1, 0};
      tbl[10] = '{0, 0, 0, 0, 0,  0, 0, 0, EENTRY, 2'd2, 1};
      tbl[11] = '{0, 0, 0, 0, 1,  0, 0, 0, EENTRY, 2'd2, 1};
      tbl[12] = '{0, 0, 0, 0, 0,  0, 0, 0, EENTRY, 2'd1, 0};
      tbl[13] = '{0, 1, 0, 1, 1,  1, 1, 0, EENTRY, 2'd1, 0};
      tbl[14] = '{0, 0, 1, 0, 1,  0, 1, 1, ERA,    2'd1, 0};
      tbl[15] = '{0, 0, 0, 0, 0,  0, 0, 0, ERA,    2'd0, 0};
      tbl[16] = '{0, 0, 0, 1, 0,  0, 0, 0, ERA,    2'd0, 0};
      tbl[17] = '{0, 0, 0, 1, 0,  0, 0, 0, ERA,    2'd1, 0};
      tbl[18] = '{0, 1, 0, 0, 0,  1, 0, 0, ERA,    2'd2, 1};
      tbl[19] = '{0, 0, 1, 0, 1,  0, 1, 1, ERA,    2'd2, 1};
      tbl[20] = '{0, 0, 0, 0, 1,  0, 1, 0, ERA,    2'd1, 0};
      tbl[21] = '{0, 0, 0, 1, 0,  0, 0, 0, ERA,    2'd0, 0};
      tbl[22] = '{0, 0, 0, 0, 1,  0, 0, 0, ERA,    2'd1, 0};
      tbl[23] = '{0, 0, 0, 0, 0,  0, 0, 0, ERA,    2'd0, 0};
      tbl[24] = '{1, 0, 0, 0, 0,  1, 0, 0, ERA,    2'd0, 0};
      tbl[25] = '{0, 1, 1, 0, 0,  1, 0, 1, EENTRY, 2'd0, 0};
      tbl[26] = '{0, 0, 0, 0, 0,  0, 0, 1, ERA,    2'd0, 0};
      tbl[27] = '{0, 0, 1, 0, 0,  0, 0, 1, ERA,    2'd0, 0};
      tbl[28] = '{0, 0, 0, 0, 0,  0, 0, 0, ERA,    2'd0, 0};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      csr_eentry = EENTRY;
      csr_era    = ERA;
      model_reset();
      #1;
      chk("rst_rvalid", {31'b0, redirect_valid}, 32'h0);
      chk("rst_pc", redirect_pc, 32'h0);
      chk("rst_outst", {30'b0, outstanding}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].wb, tbl[i].er, tbl[i].rdy, tbl[i].fire, tbl[i].dok);
         cyc(1'b1, tbl[i]);
      end

      // Asynchronous reset while redirecting with two stale requests pending.
      drive(0, 0, 0, 1, 0); cyc(1'b0, dummy);
      drive(0, 0, 0, 1, 0); cyc(1'b0, dummy);
      drive(1, 0, 0, 0, 0); cyc(1'b0, dummy);
      drive(0, 0, 0, 0, 0);
      chk("pre_rst_rvalid", {31'b0, redirect_valid}, 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("arst_rvalid", {31'b0, redirect_valid}, 32'h0);
      chk("arst_pc", redirect_pc, 32'h0);
      chk("arst_outst", {30'b0, outstanding}, 32'h0);
      chk("arst_stall", {31'b0, ifetch_stall}, 32'h0);
      chk("arst_flush", {31'b0, flush}, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0, 0, 0, 1, 0); cyc(1'b0, dummy);
      drive(0, 0, 0, 0, 1);
      #1;
      chk("post_rst_drop", {31'b0, inst_data_drop}, 32'h0);
      cyc(1'b0, dummy);

      // Random traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         csr_eentry = $urandom;
         csr_era    = $urandom;
         drive(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 2) == 0,
               (($urandom % 5) < 2) && (m_q.size() < MAXO), ($urandom % 5) < 2);
         cyc(1'b0, dummy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
